// File: rtl/bconv_interface.sv
`default_nettype none
// ============================================================================
// Module  : bconv_interface
// Purpose : XNOR-popcount 3x3 binary convolution, one output row per clock,
//           full 26x26 frame published atomically every 27 cycles.
// Revision: 1.0
// ============================================================================
module bconv_interface #(
  parameter int IN_DIM  = 28,
  parameter int K_DIM   = 3,
  parameter int OUT_DIM = IN_DIM - K_DIM + 1,
  parameter int CNT_W   = 4
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic [IN_DIM-1:0][IN_DIM-1:0]              layer_i,
  input  logic [K_DIM-1:0][K_DIM-1:0]                kernel,
  output logic [OUT_DIM-1:0][OUT_DIM-1:0][CNT_W-1:0] layer_o,
  output logic                                       layer_valid,
  output logic                                       frame_done
);

  localparam int                c_ph_w    = $clog2(OUT_DIM + 1);
  localparam logic [c_ph_w-1:0] c_last_ph = c_ph_w'(OUT_DIM);

  logic [c_ph_w-1:0]                         r_ph;
  logic [IN_DIM-1:0][IN_DIM-1:0]             r_snap_img;
  logic [K_DIM-1:0][K_DIM-1:0]               r_snap_k;
  logic [OUT_DIM-1:0][OUT_DIM-1:0][CNT_W-1:0] r_work;

  logic [c_ph_w-1:0]                         w_row_idx;
  logic [K_DIM-1:0][c_ph_w-1:0]              w_src_idx;
  logic [K_DIM-1:0][IN_DIM-1:0]              w_src_rows;
  logic [OUT_DIM-1:0][CNT_W-1:0]             w_row;
  logic [OUT_DIM-1:0][OUT_DIM-1:0][CNT_W-1:0] w_pub;

  function automatic logic [CNT_W-1:0] popcount(input logic [K_DIM*K_DIM-1:0] bits);
    logic [CNT_W-1:0] sum;
    sum = '0;
    for (int n = 0; n < K_DIM * K_DIM; n++)
      sum = sum + CNT_W'(bits[n]);
    return sum;
  endfunction

  // Phase k (1..OUT_DIM) produces output row k-1; phase 0 only snapshots.
  assign w_row_idx = (r_ph == '0) ? '0 : r_ph - 1'b1;

  generate
    for (genvar i = 0; i < K_DIM; i++) begin : g_src_row
      assign w_src_idx[i]  = w_row_idx + c_ph_w'(i);
      assign w_src_rows[i] = r_snap_img[w_src_idx[i]];
    end

    for (genvar c = 0; c < OUT_DIM; c++) begin : g_col
      logic [K_DIM*K_DIM-1:0] w_match;
      for (genvar i = 0; i < K_DIM; i++) begin : g_ki
        for (genvar j = 0; j < K_DIM; j++) begin : g_kj
          assign w_match[i*K_DIM+j] = ~(w_src_rows[i][c+j] ^ r_snap_k[i][j]);
        end
      end
      assign w_row[c] = popcount(w_match);
    end
  endgenerate

  // The final row bypasses the working buffer so the published frame is whole.
  always_comb begin
    w_pub              = r_work;
    w_pub[OUT_DIM-1]   = w_row;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ph        <= '0;
      r_snap_img  <= '0;
      r_snap_k    <= '0;
      r_work      <= '0;
      layer_o     <= '0;
      layer_valid <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      r_ph       <= (r_ph == c_last_ph) ? '0 : r_ph + 1'b1;
      frame_done <= 1'b0;
      if (r_ph == '0) begin
        r_snap_img <= layer_i;
        r_snap_k   <= kernel;
      end else begin
        r_work[w_row_idx] <= w_row;
        if (r_ph == c_last_ph) begin
          layer_o     <= w_pub;
          frame_done  <= 1'b1;
          layer_valid <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bconv_interface.sv
`default_nettype none
// ============================================================================
// Module  : tb_bconv_interface
// Purpose : Directed + randomized self-checking bench for bconv_interface.
// Revision: 1.0
// ============================================================================
module tb_bconv_interface;

  typedef logic [27:0][27:0]     img_t;
  typedef logic [2:0][2:0]       ker_t;
  typedef logic [25:0][25:0][3:0] frame_t;

  logic   clk = 1'b0;
  logic   rst_n;
  img_t   layer_i;
  ker_t   kernel;
  frame_t layer_o;
  logic   layer_valid;
  logic   frame_done;

  int     checks = 0;
  int     errors = 0;
  frame_t exp_prev;
  frame_t exp_cur;
  frame_t zero_frame;
  img_t   img_a;
  ker_t   ker_a;
  int     n;

  always #5 clk = ~clk;

  bconv_interface dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .layer_i    (layer_i),
    .kernel     (kernel),
    .layer_o    (layer_o),
    .layer_valid(layer_valid),
    .frame_done (frame_done)
  );

  // Direct definition: count kernel positions equal to the image pixel.
  function automatic frame_t model(input img_t img, input ker_t k);
    frame_t f;
    for (int r = 0; r < 26; r++)
      for (int c = 0; c < 26; c++) begin
        int cnt;
        cnt = 0;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            if (img[r+i][c+j] == k[i][j]) cnt++;
        f[r][c] = 4'(cnt);
      end
    return f;
  endfunction

  function automatic img_t rand_img();
    img_t m;
    for (int r = 0; r < 28; r++) m[r] = 28'($urandom());
    return m;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_frame(input string tag, input frame_t exp);
    for (int r = 0; r < 26; r++)
      chk($sformatf("%s_row%0d", tag, r), 128'(layer_o[r]), 128'(exp[r]));
  endtask

  // Advance until frame_done; layer_o must hold exp_prev and layer_valid must
  // equal vexp on every edge before the pulse.
  task automatic wait_frame(input string tag, input logic vexp, output int edges);
    logic stable_ok, valid_ok;
    stable_ok = 1'b1;
    valid_ok  = 1'b1;
    edges     = 0;
    do begin
      @(posedge clk);
      #1;
      edges++;
      if (frame_done !== 1'b1) begin
        if (layer_o !== exp_prev) stable_ok = 1'b0;
        if (layer_valid !== vexp) valid_ok = 1'b0;
      end
    end while (frame_done !== 1'b1 && edges < 60);
    chk({tag, "_stable"}, 128'(stable_ok), 128'(1));
    chk({tag, "_valid_before"}, 128'(valid_ok), 128'(1));
    chk({tag, "_valid_after"}, 128'(layer_valid), 128'(1));
    @(posedge clk);
    #1;
    chk({tag, "_done_one_cycle"}, 128'(frame_done), 128'(0));
    edges++;
  endtask

  initial begin
    zero_frame = '0;
    rst_n      = 1'b0;
    layer_i    = rand_img();
    kernel     = 9'($urandom());

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_frame("reset_layer_o", zero_frame);
    chk("reset_valid", 128'(layer_valid), 128'(0));
    chk("reset_done", 128'(frame_done), 128'(0));

    // Stripe image; first frame latency from reset release
    for (int r = 0; r < 28; r++) layer_i[r] = 28'hAAAAAAA;
    kernel   = {3'b101, 3'b010, 3'b101};
    rst_n    = 1'b1;
    exp_prev = zero_frame;
    wait_frame("stripe", 1'b0, n);
    chk("stripe_latency", 128'(n), 128'(28));
    exp_cur = model(layer_i, kernel);
    // wait_frame consumed one edge past the pulse; layer_o must still hold
    chk_frame("stripe", exp_cur);
    chk("stripe_even", 128'(layer_o[7][4]), 128'(3));
    chk("stripe_odd", 128'(layer_o[20][9]), 128'(6));
    exp_prev = exp_cur;

    // Inputs changed here are sampled at the next phase-0 edge, which has
    // already passed; so the following frame still re-publishes stripe data.
    layer_i = '0;
    kernel  = '0;
    wait_frame("repub", 1'b1, n);
    chk("repub_period", 128'(n), 128'(27));
    chk_frame("repub", exp_prev);

    // Frames from here: wait_frame leaves us 1 edge after the pulse, i.e. just
    // after the phase-0 snapshot edge, so new inputs land one frame later.
    wait_frame("zeros", 1'b1, n);
    chk("zeros_period", 128'(n), 128'(27));
    chk("zeros_count", 128'(layer_o[13][13]), 128'(9));
    chk_frame("zeros", model('0, '0));
    exp_prev = model('0, '0);

    layer_i = '1;
    wait_frame("ones_lag", 1'b1, n);
    chk_frame("ones_lag", exp_prev);
    wait_frame("ones", 1'b1, n);
    chk("ones_count", 128'(layer_o[10][10]), 128'(0));
    chk_frame("ones", model('1, '0));
    exp_prev = model('1, '0);

    layer_i = '0;
    layer_i[5][7] = 1'b1;
    wait_frame("single_lag", 1'b1, n);
    wait_frame("single", 1'b1, n);
    chk("single_hit", 128'(layer_o[4][6]), 128'(8));
    chk("single_corner", 128'(layer_o[3][7]), 128'(8));
    chk("single_miss", 128'(layer_o[2][6]), 128'(9));
    chk_frame("single", model(layer_i, kernel));
    exp_prev = model(layer_i, kernel);

    // Randomized frames, continuous run
    for (int t = 0; t < 3; t++) begin
      frame_t pend;
      pend    = exp_prev;
      layer_i = rand_img();
      kernel  = 9'($urandom());
      exp_cur = model(layer_i, kernel);
      wait_frame("rand_lag", 1'b1, n);
      chk("rand_lag_period", 128'(n), 128'(27));
      chk_frame("rand_lag", pend);
      wait_frame("rand", 1'b1, n);
      chk("rand_period", 128'(n), 128'(27));
      chk_frame("rand", exp_cur);
      exp_prev = exp_cur;
    end

    // Mid-frame input change: snapshot A was taken, change to B at ph=10.
    // Flush one frame so A is the live snapshot of the next frame.
    img_a   = rand_img();
    ker_a   = 9'($urandom());
    layer_i = img_a;
    kernel  = ker_a;
    wait_frame("mid_prep", 1'b1, n);
    chk_frame("mid_prep", exp_prev);
    exp_prev = exp_prev;
    // Now 1 edge past the pulse: snapshot of A taken at that edge (ph=0).
    repeat (9) @(posedge clk);
    #1;
    layer_i = rand_img();
    kernel  = 9'($urandom());
    wait_frame("mid_old", 1'b1, n);
    chk("mid_old_edges", 128'(n), 128'(18));
    chk_frame("mid_old", model(img_a, ker_a));
    exp_prev = model(img_a, ker_a);
    wait_frame("mid_new", 1'b1, n);
    chk("mid_new_period", 128'(n), 128'(27));
    chk_frame("mid_new", model(layer_i, kernel));

    // Reset during ph=15; currently 1 edge past the pulse (ph=0 edge passed)
    repeat (14) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk_frame("midrst_layer_o", zero_frame);
    chk("midrst_valid", 128'(layer_valid), 128'(0));
    chk("midrst_done", 128'(frame_done), 128'(0));
    layer_i  = rand_img();
    kernel   = 9'($urandom());
    rst_n    = 1'b1;
    exp_prev = zero_frame;
    wait_frame("post_rst", 1'b0, n);
    chk("post_rst_latency", 128'(n), 128'(28));
    chk_frame("post_rst", model(layer_i, kernel));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
